fc_hwacc_ctrl: RTL and testbench
================================

# fc_hwacc_ctrl

APB-programmed job controller for a fabric-controller hardware accelerator. It holds argument registers and a JOB_DEPTH-deep job queue with wrapping job IDs, and hands jobs to the accelerator core over a valid/ready handshake. It tracks core completion to drive a real busy flag and N_EVT selectable event lines. It sits between the FC APB peripheral bus and the accelerator datapath, which owns the TCDM master ports.

## Interface
- APB_ADDR_WIDTH, 32, APB address width; only paddr[11:0] is decoded.
- N_ARGS, 8, number of 32-bit job argument registers (1..16).
- JOB_DEPTH, 4, job queue entries (power of two, ≥2).
- ID_WIDTH, 8, job ID width.
- N_EVT, 2, number of event lines (1..4).
---
- clk_i  in  1  clock; single domain.
- rst_i  in  1  reset, synchronous, active-high.
- paddr_i  in  APB_ADDR_WIDTH  APB address.
- pwdata_i  in  32  APB write data.
- pwrite_i  in  1  APB write.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- prdata_o  out  32  APB read data.
- pready_o  out  1  APB ready.
- pslverr_o  out  1  APB error.
- job_valid_o  out  1  queue head valid.
- job_ready_i  in  1  core accepts job.
- job_args_o  out  N_ARGS*32  head job arguments; ARG[0] is in the LSBs.
- job_id_o  out  ID_WIDTH  head job ID.
- done_i  in  1  one-cycle pulse: the running job has finished.
- evt_o  out  N_EVT  one-cycle completion events.
- busy_o  out  1  queue non-empty or a job is running.

## Operation
- Register map (byte offsets):
  - 0x00 TRIGGER (W): push {ARG[], NEXT_ID} into the queue.
  - 0x04 STATUS (R): [0] busy, [1] full, [2] empty, [3] sticky err, [15:8] queue count.
  - 0x08 NEXT_ID (R).
  - 0x0C EVT_SEL (RW): [1:0] selects the evt_o line.
  - 0x10 DONE_CNT (R; any write clears it).
  - 0x40+4k ARG[k] (RW).
- Access rules:
  - Undecoded address, or a write to a read-only register: pslverr_o=1, prdata_o=0, no side effect.
  - Writing STATUS with bit3 set clears err.
- TRIGGER while full: pslverr_o=1, no push, NEXT_ID unchanged.
- Accepted push: NEXT_ID increments and wraps from 2^ID_WIDTH-1 to 0.
- Pop on job_valid_o && job_ready_i. Running state (IDLE/RUN):
  - Handshake sets RUN.
  - done_i in RUN: clear RUN, DONE_CNT+1 (wraps at 2^32), evt_o[EVT_SEL] pulses.
  - done_i and handshake in the same cycle: stays in RUN and the event still fires.
  - done_i in IDLE: ignored, sets err.
- Handshake is accepted in RUN; the core is responsible for its own serialisation.
- busy_o = !empty || RUN.

## Timing
- Reset values: all outputs 0, queue empty, NEXT_ID 0, ARG 0, EVT_SEL 0, DONE_CNT 0, err 0, state IDLE. pready_o is 0 in reset and 1 after reset.
- APB is zero-wait: the access completes in the psel&penable cycle, and prdata_o/pslverr_o are combinational in that cycle.
- TRIGGER in cycle t: job_valid_o and busy_o are high from t+1.
- job_args_o and job_id_o are stable while job_valid_o && !job_ready_i.
- Writing ARG after a push does not alter the queued copy.
- Push when full and a pop in the same cycle: the push is rejected, because fullness is taken from the registered count.
- Push and pop in the same cycle when not full: count is unchanged.
- done_i at t: evt_o pulse at t+1 (registered); DONE_CNT and busy_o update at t+1.
- Reset mid-job: everything returns to reset values on the next edge and queued jobs are lost.

## Configuration
- FC_HWACC_CTRL_PERF_EN defined:
  - Adds a 32-bit BUSY_CYC counter at 0x14 that increments every cycle busy_o=1, saturates at 0xFFFFFFFF, and is cleared by any write.
- FC_HWACC_CTRL_PERF_EN undefined:
  - 0x14 is undecoded (pslverr_o=1) and the counter logic is absent.

## Structure
- Package fc_hwacc_ctrl_pkg holds:
  - Register offset localparams.
  - STATUS bit indices.
  - A parametrised job_t struct (args and id), built by width functions.
- Sub-module fc_hwacc_job_fifo: a synchronous FIFO of job_t.
  - Pointer width $clog2(JOB_DEPTH) with wrap.
  - Count width $clog2(JOB_DEPTH)+1.
  - Full/empty derived from count.
- Top level contains the APB decode, the IDLE/RUN FSM, counters and the event register.

## Test plan
- Reset, then read STATUS → 0x00000004; NEXT_ID → 0; job_valid_o=0, busy_o=0.
- Write ARG0=0xA5A5_0001, TRIGGER; hold job_ready_i=0 → job_valid_o=1 next cycle with job_id_o=0 and job_args_o[31:0]=0xA5A5_0001; NEXT_ID=1.
- Five TRIGGERs with job_ready_i=0 (JOB_DEPTH=4) → fifth gets pslverr_o=1; STATUS count=4, full=1; NEXT_ID=4.
- EVT_SEL=1; accept a job, pulse done_i → evt_o=2'b10 for exactly one cycle, one cycle later; DONE_CNT=1; busy_o drops when the queue is empty.
- Pulse done_i in IDLE → STATUS[3]=1, no event; writing STATUS with 0x8 clears it. Also: 256 pushes/pops with ID_WIDTH=8 → the ID wraps 255→0.
- FC_HWACC_CTRL_PERF_EN defined: 10 busy cycles → BUSY_CYC reads 10. Undefined: reading 0x14 gives pslverr_o=1.

Source files
------------

// File: rtl/fc_hwacc_ctrl_pkg.sv
// Shared definitions for the accelerator job controller: register map, STATUS layout,
// run-state encoding and the width helpers used to build the job record.
package fc_hwacc_ctrl_pkg;

  localparam logic [11:0] OFF_TRIGGER  = 12'h000;
  localparam logic [11:0] OFF_STATUS   = 12'h004;
  localparam logic [11:0] OFF_NEXT_ID  = 12'h008;
  localparam logic [11:0] OFF_EVT_SEL  = 12'h00C;
  localparam logic [11:0] OFF_DONE_CNT = 12'h010;
  localparam logic [11:0] OFF_BUSY_CYC = 12'h014;
  localparam logic [11:0] OFF_ARG_BASE = 12'h040;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_ERR     = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_MSB = 15;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_e;

  function automatic int job_args_w(input int n_args);
    return n_args * 32;
  endfunction

  function automatic int job_w(input int n_args, input int id_w);
    return job_args_w(n_args) + id_w;
  endfunction

endpackage

// File: rtl/fc_hwacc_job_fifo.sv
// Synchronous job queue; occupancy comes from a registered count, so a push into a
// full queue is refused even when the same cycle pops.
module fc_hwacc_job_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fc_hwacc_ctrl.sv
// APB job controller for the FC accelerator: argument registers, job queue, IDLE/RUN
// tracking and completion events. Define FC_HWACC_CTRL_PERF_EN to add the BUSY_CYC counter.
module fc_hwacc_ctrl
  import fc_hwacc_ctrl_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int N_ARGS         = 8,
  parameter int JOB_DEPTH      = 4,
  parameter int ID_WIDTH       = 8,
  parameter int N_EVT          = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      job_valid_o,
  input  logic                      job_ready_i,
  output logic [N_ARGS*32-1:0]      job_args_o,
  output logic [ID_WIDTH-1:0]       job_id_o,
  input  logic                      done_i,
  output logic [N_EVT-1:0]          evt_o,
  output logic                      busy_o
);

  localparam int CNT_W  = $clog2(JOB_DEPTH) + 1;
  localparam int ARG_AW = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;

  typedef struct packed {
    logic [job_args_w(N_ARGS)-1:0] args;
    logic [ID_WIDTH-1:0]           id;
  } job_t;

  logic [11:0]         addr;
  logic                ready;
  logic                access;
  logic [31:0]         rdata;
  logic                slverr;
  logic                trig;
  logic                st_wr;
  logic                evt_wr;
  logic                cnt_wr;
  logic                arg_wr;
  logic                arg_hit;
  logic [ARG_AW-1:0]   arg_idx;
  logic [31:0]         args [N_ARGS];
  logic [ID_WIDTH-1:0] next_id;
  logic [1:0]          evt_sel;
  logic [31:0]         done_cnt;
  logic                err;
  logic [31:0]         status;
  logic [N_EVT-1:0]    evt_n;
  logic [N_EVT-1:0]    evt_q;
  job_t                job_in;
  job_t                job_head;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;
  logic                handshake;
  logic                done_ok;
  logic                done_err;
  run_state_e          state_q;
  run_state_e          state_n;
`ifdef FC_HWACC_CTRL_PERF_EN
  logic                perf_wr;
  logic [31:0]         busy_cyc;
`endif

  if (APB_ADDR_WIDTH > 12) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^paddr_i[APB_ADDR_WIDTH-1:12];
  end

  assign addr    = paddr_i[11:0];
  assign access  = psel_i && penable_i && ready;
  assign arg_idx = addr[ARG_AW+1:2];
  assign arg_hit = (addr[11:6] == OFF_ARG_BASE[11:6]) && (int'(addr[5:2]) < N_ARGS);

  always_comb begin
    status = '0;
    status[ST_BUSY]                = busy_o;
    status[ST_FULL]                = full;
    status[ST_EMPTY]               = empty;
    status[ST_ERR]                 = err;
    status[ST_CNT_MSB:ST_CNT_LSB]  = 8'(count);
  end

  // APB decode: errors always return zero data and suppress every side effect.
  always_comb begin
    rdata  = '0;
    slverr = 1'b0;
    trig   = 1'b0;
    st_wr  = 1'b0;
    evt_wr = 1'b0;
    cnt_wr = 1'b0;
    arg_wr = 1'b0;
`ifdef FC_HWACC_CTRL_PERF_EN
    perf_wr = 1'b0;
`endif
    if (access) begin
      if (addr[1:0] != 2'b00) begin
        slverr = 1'b1;
      end else begin
        case (addr)
          OFF_TRIGGER: begin
            if (pwrite_i) begin
              if (full) slverr = 1'b1;
              else      trig   = 1'b1;
            end
          end
          OFF_STATUS: begin
            if (pwrite_i) st_wr = 1'b1;
            else          rdata = status;
          end
          OFF_NEXT_ID: begin
            if (pwrite_i) slverr = 1'b1;
            else          rdata  = 32'(next_id);
          end
          OFF_EVT_SEL: begin
            if (pwrite_i) evt_wr = 1'b1;
            else          rdata  = {30'b0, evt_sel};
          end
          OFF_DONE_CNT: begin
            if (pwrite_i) cnt_wr = 1'b1;
            else          rdata  = done_cnt;
          end
`ifdef FC_HWACC_CTRL_PERF_EN
          OFF_BUSY_CYC: begin
            if (pwrite_i) perf_wr = 1'b1;
            else          rdata   = busy_cyc;
          end
`endif
          default: begin
            if (!arg_hit)      slverr = 1'b1;
            else if (pwrite_i) arg_wr = 1'b1;
            else               rdata  = args[arg_idx];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready    <= 1'b0;
      next_id  <= '0;
      evt_sel  <= '0;
      done_cnt <= '0;
      err      <= 1'b0;
      evt_q    <= '0;
      state_q  <= IDLE;
    end else begin
      ready   <= 1'b1;
      evt_q   <= evt_n;
      state_q <= state_n;
      if (trig)   next_id <= next_id + 1'b1;
      if (evt_wr) evt_sel <= pwdata_i[1:0];
      if (cnt_wr)       done_cnt <= '0;
      else if (done_ok) done_cnt <= done_cnt + 32'd1;
      if (done_err)                     err <= 1'b1;
      else if (st_wr && pwdata_i[ST_ERR]) err <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_ARGS; k++) args[k] <= '0;
    end else if (arg_wr) begin
      args[arg_idx] <= pwdata_i;
    end
  end

  // Snapshot of the argument bank; the queue keeps its own copy per job.
  always_comb begin
    job_in    = '0;
    job_in.id = next_id;
    for (int k = 0; k < N_ARGS; k++) job_in.args[k*32 +: 32] = args[k];
  end

  fc_hwacc_job_fifo #(
    .WIDTH (job_w(N_ARGS, ID_WIDTH)),
    .DEPTH (JOB_DEPTH)
  ) u_job_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (trig),
    .push_data (job_in),
    .pop       (handshake),
    .head      (job_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign job_valid_o = !empty;
  assign handshake   = job_valid_o && job_ready_i;
  assign job_args_o  = empty ? '0 : job_head.args;
  assign job_id_o    = empty ? '0 : job_head.id;

  // A handshake always wins: a job handed over in the cycle another finishes keeps RUN.
  always_comb begin
    state_n  = state_q;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (done_i)    done_err = 1'b1;
        if (handshake) state_n  = RUN;
      end
      RUN: begin
        if (done_i) done_ok = 1'b1;
        if (handshake)   state_n = RUN;
        else if (done_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    evt_n = '0;
    for (int i = 0; i < N_EVT; i++) begin
      if (done_ok && (evt_sel == 2'(i))) evt_n[i] = 1'b1;
    end
  end

`ifdef FC_HWACC_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                    busy_cyc <= '0;
    else if (perf_wr)             busy_cyc <= '0;
    else if (busy_o && (busy_cyc != 32'hFFFF_FFFF)) busy_cyc <= busy_cyc + 32'd1;
  end
`endif

  assign busy_o    = !empty || (state_q == RUN);
  assign evt_o     = evt_q;
  assign prdata_o  = rdata;
  assign pslverr_o = slverr;
  assign pready_o  = ready;

endmodule

// File: tb/tb_fc_hwacc_ctrl.sv
// Scoreboard bench for fc_hwacc_ctrl: stimulus queues expected APB responses, jobs and
// events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_fc_hwacc_ctrl;

  typedef struct {
    string       nm;
    bit          wr;
    logic [31:0] rd;
    bit          err;
  } apb_exp_t;

  typedef struct {
    logic [7:0]  id;
    logic [63:0] args;
  } job_exp_t;

  typedef struct {
    logic [1:0] evt;
    int         cyc;
  } evt_exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  paddr = '0;
  logic [31:0]  pwdata = '0;
  logic         pwrite = 1'b0;
  logic         psel = 1'b0;
  logic         penable = 1'b0;
  logic [31:0]  prdata;
  logic         pready;
  logic         pslverr;
  logic         job_valid;
  logic         job_ready = 1'b0;
  logic [255:0] job_args;
  logic [7:0]   job_id;
  logic         done = 1'b0;
  logic [1:0]   evt;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  apb_exp_t apb_q[$];
  job_exp_t job_q[$];
  evt_exp_t evt_q[$];

  logic [7:0]  nid  = 8'd0;
  logic [31:0] arg0 = '0;
  logic [31:0] arg1 = '0;

  fc_hwacc_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .pwrite_i    (pwrite),
    .psel_i      (psel),
    .penable_i   (penable),
    .prdata_o    (prdata),
    .pready_o    (pready),
    .pslverr_o   (pslverr),
    .job_valid_o (job_valid),
    .job_ready_i (job_ready),
    .job_args_o  (job_args),
    .job_id_o    (job_id),
    .done_i      (done),
    .evt_o       (evt),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  apb_exp_t ae;
  job_exp_t je;
  evt_exp_t ee;

  always @(negedge clk) begin
    if (!rst && psel && penable && pready) begin
      if (apb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL apb_unexpected: access at 0x%0h with nothing queued", paddr);
      end else begin
        ae = apb_q.pop_front();
        check({ae.nm, "_slverr"}, 64'(pslverr), 64'(ae.err));
        if (!ae.wr) check({ae.nm, "_rdata"}, 64'(prdata), 64'(ae.rd));
      end
    end
    if (!rst && job_valid && job_ready) begin
      if (job_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL job_unexpected: id 0x%0h handed over, none queued", job_id);
      end else begin
        je = job_q.pop_front();
        check("job_id", 64'(job_id), 64'(je.id));
        check("job_args", job_args[63:0], je.args);
      end
    end
    if (evt != 2'b00) begin
      if (evt_q.size() == 0) begin
        check("evt_unexpected", 64'(evt), 64'd0);
      end else begin
        ee = evt_q.pop_front();
        check("evt_value", 64'(evt), 64'(ee.evt));
        check("evt_cycle", 64'(cyc), 64'(ee.cyc));
      end
    end
  end

  task automatic apb(input string nm, input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_err);
    apb_q.push_back('{nm: nm, wr: wr, rd: exp_rd, err: exp_err});
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {20'd0, a}; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr_arg(input int k, input logic [31:0] d);
    if (k == 0) arg0 = d;
    if (k == 1) arg1 = d;
    apb("arg_wr", 1'b1, 12'h040 + 12'(4 * k), d, 32'd0, 1'b0);
  endtask

  task automatic trigger(input bit exp_err);
    if (!exp_err) begin
      job_q.push_back('{id: nid, args: {arg1, arg0}});
      nid = nid + 8'd1;
    end
    apb("trigger", 1'b1, 12'h000, 32'd0, 32'd0, exp_err);
  endtask

  task automatic pop_job();
    job_ready = 1'b1;
    @(posedge clk); #1;
    job_ready = 1'b0;
  endtask

  task automatic pulse_done(input bit with_pop, input logic [1:0] exp_evt);
    if (exp_evt != 2'b00) evt_q.push_back('{evt: exp_evt, cyc: cyc + 1});
    done = 1'b1;
    job_ready = with_pop;
    @(posedge clk); #1;
    done = 1'b0;
    job_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", 64'(pready), 64'd0);
    check("rst_job_valid", 64'(job_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_evt", 64'(evt), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("pready_after_rst", 64'(pready), 64'd1);

    apb("status_rst", 1'b0, 12'h004, 32'd0, 32'h0000_0004, 1'b0);
    apb("next_id_rst", 1'b0, 12'h008, 32'd0, 32'd0, 1'b0);
`ifdef FC_HWACC_CTRL_PERF_EN
    apb("busy_cyc_rst", 1'b0, 12'h014, 32'd0, 32'd0, 1'b0);
`else
    apb("busy_cyc_undecoded", 1'b0, 12'h014, 32'd0, 32'd0, 1'b1);
`endif

    // First job: head appears the cycle after TRIGGER and keeps its own argument copy.
    wr_arg(0, 32'hA5A5_0001);
    wr_arg(1, 32'hDEAD_BEEF);
    apb("arg1_rd", 1'b0, 12'h044, 32'd0, 32'hDEAD_BEEF, 1'b0);
    trigger(1'b0);
    check("valid_after_trig", 64'(job_valid), 64'd1);
    check("busy_after_trig", 64'(busy), 64'd1);
    check("head_id", 64'(job_id), 64'd0);
    check("head_arg0", 64'(job_args[31:0]), 64'hA5A5_0001);
    apb("next_id_1", 1'b0, 12'h008, 32'd0, 32'd1, 1'b0);
    wr_arg(0, 32'h1111_2222);
    check("head_arg0_kept", 64'(job_args[31:0]), 64'hA5A5_0001);

    // Fill the queue; the fifth trigger bounces.
    trigger(1'b0);
    trigger(1'b0);
    trigger(1'b0);
    trigger(1'b1);
    apb("status_full", 1'b0, 12'h004, 32'd0, 32'h0000_0403, 1'b0);
    apb("next_id_4", 1'b0, 12'h008, 32'd0, 32'd4, 1'b0);
    apb("next_id_wr_ro", 1'b1, 12'h008, 32'h55, 32'd0, 1'b1);
    apb("undecoded_rd", 1'b0, 12'h020, 32'd0, 32'd0, 1'b1);
    apb("misaligned_rd", 1'b0, 12'h042, 32'd0, 32'd0, 1'b1);
    apb("arg0_rd", 1'b0, 12'h040, 32'd0, 32'h1111_2222, 1'b0);

    // Drain with completions, including a done that coincides with a handshake.
    apb("evt_sel_1", 1'b1, 12'h00C, 32'd1, 32'd0, 1'b0);
    pop_job();
    pulse_done(1'b0, 2'b10);
    apb("done_cnt_1", 1'b0, 12'h010, 32'd0, 32'd1, 1'b0);
    apb("evt_sel_0", 1'b1, 12'h00C, 32'd0, 32'd0, 1'b0);
    apb("evt_sel_rd", 1'b0, 12'h00C, 32'd0, 32'd0, 1'b0);
    pop_job();
    pulse_done(1'b1, 2'b01);
    pop_job();
    check("busy_run_empty", 64'(busy), 64'd1);
    check("valid_empty", 64'(job_valid), 64'd0);
    pulse_done(1'b0, 2'b01);
    check("busy_idle_empty", 64'(busy), 64'd0);
    apb("done_cnt_3", 1'b0, 12'h010, 32'd0, 32'd3, 1'b0);
    apb("status_drained", 1'b0, 12'h004, 32'd0, 32'h0000_0004, 1'b0);

    // Spurious done while idle: sticky error, no event.
    pulse_done(1'b0, 2'b00);
    apb("status_err", 1'b0, 12'h004, 32'd0, 32'h0000_000C, 1'b0);
    apb("status_clr", 1'b1, 12'h004, 32'h8, 32'd0, 1'b0);
    apb("status_cleared", 1'b0, 12'h004, 32'd0, 32'h0000_0004, 1'b0);
    apb("done_cnt_clr", 1'b1, 12'h010, 32'h1234, 32'd0, 1'b0);
    apb("done_cnt_0", 1'b0, 12'h010, 32'd0, 32'd0, 1'b0);

    // 256 push/pop pairs take the ID through 255 -> 0 and back to 4.
    for (int i = 0; i < 256; i++) begin
      trigger(1'b0);
      pop_job();
    end
    apb("next_id_wrapped", 1'b0, 12'h008, 32'd0, 32'd4, 1'b0);
    pulse_done(1'b0, 2'b01);
    check("busy_after_wrap", 64'(busy), 64'd0);

`ifdef FC_HWACC_CTRL_PERF_EN
    apb("busy_cyc_clr", 1'b1, 12'h014, 32'd0, 32'd0, 1'b0);
    trigger(1'b0);
    pop_job();
    repeat (8) @(posedge clk);
    #1;
    pulse_done(1'b0, 2'b01);
    apb("busy_cyc_10", 1'b0, 12'h014, 32'd0, 32'd10, 1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("apb_q_drained", 64'(apb_q.size()), 64'd0);
    check("job_q_drained", 64'(job_q.size()), 64'd0);
    check("evt_q_drained", 64'(evt_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
